ex_sched: RTL and testbench

EX_SCHED -- requirements
Module: ex_sched

---
 rtl/ex_sched_pkg.sv | 20 ++
 rtl/ex_sched_rr_arbiter.sv | 32 +++
 rtl/ex_sched.sv | 149 ++++++++++++++
 tb/tb_ex_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_sched_pkg.sv
// Shared definitions for the PWM compare-value scheduler (ex_sched).
// Holds the scheduler state encoding and the channel-index width helper.
package ex_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT
    } state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ex_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel
// after last_grant, wrapping modulo NUM_CH.
module rr_arbiter
    import ex_sched_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]                 req,
    input  logic [ch_idx_w(NUM_CH)-1:0]       last_grant,
    output logic [ch_idx_w(NUM_CH)-1:0]       grant,
    output logic                              grant_valid
);

    localparam int CW = ch_idx_w(NUM_CH);

    logic [CW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant       = last_grant;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = CW'((int'(last_grant) + i) % NUM_CH);
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_sched.sv
// ex_sched: shares one instruction execution unit between NUM_CH PWM
// channels. Channel period-start requests are queued as pending bits and
// served round-robin; each result is latched into the channel's compare value.
// Optional watchdog on the execution unit: define EX_SCHED_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no execution in flight; grant a pending channel if any
//   ST_ISSUE | ex_start_o high for one cycle; granted pending bit cleared
//   ST_WAIT  | waiting for ex_done_i (or watchdog expiry when enabled)
module ex_sched
    import ex_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int VALUE_WIDTH    = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             req_i,
    output logic                          ex_start_o,
    output logic [$clog2(NUM_CH)-1:0]     ex_ch_o,
    input  logic                          ex_done_i,
    input  logic [VALUE_WIDTH-1:0]        ex_value_i,
    output logic [NUM_CH*VALUE_WIDTH-1:0] cmp_value_o,
    output logic [NUM_CH-1:0]             cmp_valid_o,
    output logic                          busy_o,
    output logic [NUM_CH-1:0]             overrun_o,
    output logic                          timeout_o
);

    localparam int            CW      = ch_idx_w(NUM_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    logic [1:0]                    state;
    logic [NUM_CH-1:0]             pending;
    logic [NUM_CH-1:0]             issue_clr;
    logic [NUM_CH-1:0]             overrun;
    logic [CW-1:0]                 cur_ch;
    logic [CW-1:0]                 last_grant;
    logic [CW-1:0]                 arb_grant;
    logic                          arb_valid;
    logic [NUM_CH*VALUE_WIDTH-1:0] cmp_value;
    logic [NUM_CH-1:0]             cmp_valid;
    logic                          wait_expired;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req         (pending),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // The channel being issued loses its pending bit unless it re-requests in that same cycle.
    assign issue_clr = (state == ST_ISSUE) ? (NUM_CH'(1) << cur_ch) : '0;

    // Pending bits and sticky overrun flags; an issue-cycle re-request is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~issue_clr) | req_i;
            overrun <= overrun | (req_i & pending & ~issue_clr);
        end
    end

`ifdef EX_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog;
    logic            timeout_q;

    // Watchdog down-counter loaded on issue; terminal count in WAIT aborts the execution.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wdog <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if ((state == ST_WAIT) && (wdog != '0)) begin
                wdog <= wdog - 1'b1;
            end
            if ((state == ST_WAIT) && !ex_done_i && (wdog == '0)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign wait_expired = (state == ST_WAIT) && (wdog == '0);
    assign timeout_o    = timeout_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // Scheduler FSM: grant, issue, wait for the result and latch it into the channel slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_ch     <= '0;
            last_grant <= LAST_CH;
            cmp_value  <= '0;
            cmp_valid  <= '0;
        end else begin
            cmp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        cur_ch <= arb_grant;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ex_done_i) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (cur_ch == CW'(k)) begin
                                cmp_value[k*VALUE_WIDTH +: VALUE_WIDTH] <= ex_value_i;
                            end
                        end
                        cmp_valid  <= NUM_CH'(1) << cur_ch;
                        last_grant <= cur_ch;
                        state      <= ST_IDLE;
                    end else if (wait_expired) begin
                        last_grant <= cur_ch;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ex_start_o  = (state == ST_ISSUE);
    assign ex_ch_o     = cur_ch;
    assign cmp_value_o = cmp_value;
    assign cmp_valid_o = cmp_valid;
    assign busy_o      = (state != ST_IDLE) || (|pending);
    assign overrun_o   = overrun;

endmodule

// File: tb/tb_ex_sched.sv
// Testbench for ex_sched: cycle-level behavioural model plus directed scenarios.
module tb_ex_sched;

    localparam int N   = 4;
    localparam int VW  = 10;
    localparam int TMO = 64;
`ifdef EX_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic            ex_done_i = 1'b0;
    logic [VW-1:0]   ex_value_i = '0;
    logic            ex_start_o;
    logic [1:0]      ex_ch_o;
    logic [N*VW-1:0] cmp_value_o;
    logic [N-1:0]    cmp_valid_o;
    logic            busy_o;
    logic [N-1:0]    overrun_o;
    logic            timeout_o;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_starts = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    ex_sched #(
        .NUM_CH         (N),
        .VALUE_WIDTH    (VW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .ex_start_o  (ex_start_o),
        .ex_ch_o     (ex_ch_o),
        .ex_done_i   (ex_done_i),
        .ex_value_i  (ex_value_i),
        .cmp_value_o (cmp_value_o),
        .cmp_valid_o (cmp_valid_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model view: a set of waiting channels, at most one job in flight
    // (announced one cycle, then executing), and a round-robin pointer.
    logic [N-1:0]    m_pend, m_ovr, m_vld;
    logic [N*VW-1:0] m_cmp;
    int              m_last, m_ch, m_wn;
    bit              m_starting, m_executing, m_tmo;

    always @(posedge clk) begin : model
        logic [N-1:0]    pend, npend, ovr, vld;
        logic [N*VW-1:0] cmpv;
        int              last, ch, wn, pick;
        bit              starting, executing, tmo, found;
        pend = m_pend; ovr = m_ovr; cmpv = m_cmp; last = m_last; ch = m_ch;
        wn = m_wn; starting = m_starting; executing = m_executing; tmo = m_tmo;
        if (rst) begin
            pend = '0; ovr = '0; vld = '0; cmpv = '0; last = N - 1; ch = 0;
            wn = 0; starting = 1'b0; executing = 1'b0; tmo = 1'b0;
        end else begin
            vld = '0;
            for (int k = 0; k < N; k++)
                if (req_i[k] && pend[k] && !(starting && k == ch)) ovr[k] = 1'b1;
            npend = pend;
            if (starting) npend[ch] = 1'b0;
            npend = npend | req_i;
            if (starting) begin
                starting  = 1'b0;
                executing = 1'b1;
                wn        = 0;
            end else if (executing) begin
                wn++;
                if (ex_done_i) begin
                    cmpv[ch*VW +: VW] = ex_value_i;
                    vld[ch]   = 1'b1;
                    last      = ch;
                    executing = 1'b0;
                end else if (TMO_EN && wn >= TMO) begin
                    last      = ch;
                    executing = 1'b0;
                    tmo       = 1'b1;
                end
            end else if (pend != '0) begin
                found = 1'b0;
                pick  = 0;
                for (int i = 1; i <= N; i++) begin
                    if (!found && pend[(last + i) % N]) begin
                        pick  = (last + i) % N;
                        found = 1'b1;
                    end
                end
                ch       = pick;
                starting = 1'b1;
            end
            pend = npend;
        end
        m_pend <= pend; m_ovr <= ovr; m_vld <= vld; m_cmp <= cmpv; m_last <= last;
        m_ch <= ch; m_wn <= wn; m_starting <= starting; m_executing <= executing; m_tmo <= tmo;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ex_start", ex_start_o, m_starting);
            if (m_starting || m_executing) check("ex_ch", ex_ch_o, m_ch);
            check("cmp_value", cmp_value_o, m_cmp);
            check("cmp_valid", cmp_valid_o, m_vld);
            check("busy", busy_o, m_starting || m_executing || (m_pend != '0));
            check("overrun", overrun_o, m_ovr);
            check("timeout", timeout_o, m_tmo);
            if (ex_start_o) n_starts++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_i = '0; ex_done_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (ex_start_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("start_seen", ex_start_o, 1'b1);
    endtask

    // Act as the execution unit: answer dly cycles after the start pulse.
    task automatic serve(input int dly, input logic [VW-1:0] val, output int ch);
        wait_start();
        ch = int'(ex_ch_o);
        repeat (dly) tick();
        ex_done_i = 1'b1; ex_value_i = val;
        tick();
        ex_done_i = 1'b0;
    endtask

    initial begin
        int ch, n0;
        int order[4];
        int exp_a[4];
        int exp_b[4];
        exp_a = '{0, 1, 2, 3};
        exp_b = '{2, 3, 0, 1};

        do_reset();
        cmp_en = 1'b1;
        check("rst_cmp_value", cmp_value_o, 0);
        check("rst_cmp_valid", cmp_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_start", ex_start_o, 0);

        // single request, result two cycles after start
        req_i = 4'b0001; tick(); req_i = '0; tick();
        check("t030_start", ex_start_o, 1);
        check("t030_ch", ex_ch_o, 0);
        tick(); tick();
        ex_done_i = 1'b1; ex_value_i = 10'h155; tick(); ex_done_i = 1'b0;
        check("t030_cmp0", cmp_value_o[9:0], 10'h155);
        check("t030_valid", cmp_valid_o, 4'b0001);

        // round-robin order from reset, then from last_grant = 1
        do_reset();
        req_i = 4'b1111; tick(); req_i = '0;
        for (int i = 0; i < 4; i++) begin
            serve(1, VW'(10'h200 + i), ch);
            order[i] = ch;
        end
        for (int i = 0; i < 4; i++) check($sformatf("t031_a_order%0d", i), order[i], exp_a[i]);
        req_i = 4'b0011; tick(); req_i = '0;
        serve(1, 10'h011, ch); serve(1, 10'h022, ch);
        req_i = 4'b1111; tick(); req_i = '0;
        for (int i = 0; i < 4; i++) begin
            serve(2, VW'(10'h300 + i), ch);
            order[i] = ch;
        end
        for (int i = 0; i < 4; i++) check($sformatf("t031_b_order%0d", i), order[i], exp_b[i]);

        // double request on ch1 before service
        do_reset();
        n0 = n_starts;
        req_i = 4'b0010; tick(); tick(); req_i = '0;
        serve(2, 10'h0AB, ch);
        check("t032_ch", ch, 1);
        repeat (10) tick();
        check("t032_starts", n_starts - n0, 1);
        check("t032_overrun", overrun_o, 4'b0010);
        check("t032_cmp1", cmp_value_o[19:10], 10'h0AB);

        // re-request of ch0 during its own issue cycle
        do_reset();
        n0 = n_starts;
        req_i = 4'b0001; tick(); req_i = '0; tick();
        check("t033_start", ex_start_o, 1);
        req_i = 4'b0001; tick(); req_i = '0;
        ex_done_i = 1'b1; ex_value_i = 10'h0AA; tick(); ex_done_i = 1'b0;
        check("t033_cmp0_a", cmp_value_o[9:0], 10'h0AA);
        serve(1, 10'h033, ch);
        check("t033_ch", ch, 0);
        check("t033_cmp0_b", cmp_value_o[9:0], 10'h033);
        check("t033_overrun", overrun_o, 0);
        repeat (4) tick();
        check("t033_starts", n_starts - n0, 2);

        // execution unit never answers
        do_reset();
        req_i = 4'b0100; tick(); req_i = '0;
        serve(1, 10'h2C3, ch);
        req_i = 4'b0100; tick(); req_i = '0;
        wait_start();
        repeat (TMO + 4) tick();
        check("t034_timeout", timeout_o, TMO_EN);
        check("t034_busy", busy_o, !TMO_EN);
        check("t034_cmp2", cmp_value_o[29:20], 10'h2C3);

        // reset mid-WAIT, then a late result
        do_reset();
        req_i = 4'b1000; tick(); req_i = '0;
        wait_start();
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        ex_done_i = 1'b1; ex_value_i = 10'h3FF; tick(); ex_done_i = 1'b0;
        tick();
        check("t035_cmp_value", cmp_value_o, 0);
        check("t035_cmp_valid", cmp_valid_o, 0);
        check("t035_busy", busy_o, 0);
        check("t035_overrun", overrun_o, 0);
        check("t035_timeout", timeout_o, 0);
        check("t035_start", ex_start_o, 0);
        check("t035_ch", ex_ch_o, 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t required < 100000", $time);
        $fatal(1);
    end

endmodule
